// File: rtl/pma_rx_deser_if.sv
`default_nettype none
// ============================================================================
// Module      : pma_rx_deser_if
// Description : Serial line inputs and aligned symbol outputs of the receive
//               PMA deserializer. The master drives the line and enable; the
//               slave (the deserializer) returns symbols and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface pma_rx_deser_if;
  logic       RX_In_P;
  logic       RX_In_N;
  logic       RX_En;
  logic [9:0] Data_out;
  logic       Data_Valid;
  logic       Comma_Det;
  logic       Symbol_Lock;
  logic       RX_Elec_Idle;

  // Line side: drives the serial pair and enable, observes symbols.
  modport master (
    output RX_In_P,
    output RX_In_N,
    output RX_En,
    input  Data_out,
    input  Data_Valid,
    input  Comma_Det,
    input  Symbol_Lock,
    input  RX_Elec_Idle
  );

  // Deserializer side.
  modport slave (
    input  RX_In_P,
    input  RX_In_N,
    input  RX_En,
    output Data_out,
    output Data_Valid,
    output Comma_Det,
    output Symbol_Lock,
    output RX_Elec_Idle
  );
endinterface
`default_nettype wire

// File: rtl/pma_rx_deser.sv
`default_nettype none
// ============================================================================
// Module      : pma_rx_deser
// Description : Receive PMA for the 8b/10b link. Shifts line bits in LSB
//               first, aligns to the K28.5 comma, emits 10-bit symbols with a
//               one-cycle valid pulse, and detects electrical idle (P == N).
// Revision    : 1.0 - initial release
// ============================================================================
module pma_rx_deser #(
  parameter logic [9:0]  COMMA_NEG   = 10'h17C,
  parameter logic [9:0]  COMMA_POS   = 10'h283,
  parameter int unsigned REALIGN_THR = 2,
  parameter int unsigned IDLE_LIMIT  = 20
) (
  input  logic          Bit_Rate_Clk,
  input  logic          Rst,
  pma_rx_deser_if.slave rx
);

  localparam logic [3:0] c_last_bit   = 4'd9;
  localparam logic [3:0] c_mis_last   = 4'(REALIGN_THR - 1);
  localparam logic [7:0] c_idle_limit = 8'(IDLE_LIMIT);
  localparam logic [7:0] c_idle_max   = 8'hFF;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t     r_state;
  logic [9:0] r_sr;
  logic [3:0] r_bit_cnt;
  logic [3:0] r_mis_cnt;
  logic [7:0] r_idle_cnt;
  logic [9:0] r_data;
  logic       r_valid;
  logic       r_comma;
  logic       r_lock;
  logic       r_elec_idle;

  logic [9:0] w_sr_next;
  logic       w_comma_hit;
  logic       w_line_idle;
  logic [7:0] w_idle_cnt_next;
  logic       w_idle_reached;

  // The newest bit enters at the top so the first bit of a symbol ends in bit 0.
  assign w_sr_next   = {rx.RX_In_P, r_sr[9:1]};
  assign w_comma_hit = (w_sr_next == COMMA_NEG) || (w_sr_next == COMMA_POS);
  assign w_line_idle = (rx.RX_In_P == rx.RX_In_N);

  // Saturating run length of P == N cycles; any differential bit restarts it.
  always_comb begin
    w_idle_cnt_next = 8'd0;
    if (w_line_idle) begin
      w_idle_cnt_next = (r_idle_cnt == c_idle_max) ? c_idle_max : r_idle_cnt + 8'd1;
    end
  end

  // Lock is dropped only on the edge where the idle run first reaches the limit.
  assign w_idle_reached = (w_idle_cnt_next == c_idle_limit);

  // Shift register and idle tracking run every edge, even while disabled.
  always_ff @(posedge Bit_Rate_Clk or posedge Rst) begin
    if (Rst) begin
      r_sr        <= '0;
      r_idle_cnt  <= '0;
      r_elec_idle <= 1'b0;
    end else begin
      r_sr        <= w_sr_next;
      r_idle_cnt  <= w_idle_cnt_next;
      r_elec_idle <= (w_idle_cnt_next >= c_idle_limit);
    end
  end

  // Alignment FSM: acquire on a comma, emit every 10 bits, realign after
  // repeated misaligned commas; disable and idle force loss of lock.
  always_ff @(posedge Bit_Rate_Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= UNLOCKED;
      r_bit_cnt <= '0;
      r_mis_cnt <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_comma   <= 1'b0;
      r_lock    <= 1'b0;
    end else if (!rx.RX_En) begin
      r_state   <= UNLOCKED;
      r_bit_cnt <= '0;
      r_mis_cnt <= '0;
      r_valid   <= 1'b0;
      r_comma   <= 1'b0;
      r_lock    <= 1'b0;
    end else if (w_idle_reached) begin
      r_state   <= UNLOCKED;
      r_bit_cnt <= '0;
      r_mis_cnt <= '0;
      r_valid   <= 1'b0;
      r_comma   <= 1'b0;
      r_lock    <= 1'b0;
    end else begin
      case (r_state)
        UNLOCKED: begin
          if (w_comma_hit) begin
            r_state   <= LOCKED;
            r_data    <= w_sr_next;
            r_valid   <= 1'b1;
            r_comma   <= 1'b1;
            r_bit_cnt <= '0;
            r_mis_cnt <= '0;
            r_lock    <= 1'b1;
          end else begin
            r_valid <= 1'b0;
            r_comma <= 1'b0;
            r_lock  <= 1'b0;
          end
        end
        LOCKED: begin
          r_lock <= 1'b1;
          if (r_bit_cnt == c_last_bit) begin
            // Symbol boundary: deliver whatever landed in the window.
            r_data    <= w_sr_next;
            r_valid   <= 1'b1;
            r_comma   <= w_comma_hit;
            r_bit_cnt <= '0;
            if (w_comma_hit) begin
              r_mis_cnt <= '0;
            end
          end else if (w_comma_hit) begin
            if (r_mis_cnt == c_mis_last) begin
              // Enough evidence the boundary moved: restart framing here.
              r_data    <= w_sr_next;
              r_valid   <= 1'b1;
              r_comma   <= 1'b1;
              r_bit_cnt <= '0;
              r_mis_cnt <= '0;
            end else begin
              r_mis_cnt <= r_mis_cnt + 4'd1;
              r_bit_cnt <= r_bit_cnt + 4'd1;
              r_valid   <= 1'b0;
              r_comma   <= 1'b0;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
            r_valid   <= 1'b0;
            r_comma   <= 1'b0;
          end
        end
        default: begin
          r_state   <= UNLOCKED;
          r_bit_cnt <= '0;
          r_mis_cnt <= '0;
          r_valid   <= 1'b0;
          r_comma   <= 1'b0;
          r_lock    <= 1'b0;
        end
      endcase
    end
  end

  assign rx.Data_out     = r_data;
  assign rx.Data_Valid   = r_valid;
  assign rx.Comma_Det    = r_comma;
  assign rx.Symbol_Lock  = r_lock;
  assign rx.RX_Elec_Idle = r_elec_idle;

endmodule
`default_nettype wire
